hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined core. It tracks the destination register, write enable, load and flag-write attributes of every instruction in flight after decode. From that state it drives the ID-stage operand forwarding selects, the flag-forward select and a load-use stall. It generalises the core's fixed two-source forwarding to a configurable pipeline depth and load-ready stage, and adds stall and flush handling.

## Interface
Parameters:
- STAGES, 3: tracked stages after ID (1=EX, 2=MEM, …, STAGES=WR); legal range 2..8.
- REG_W, 5: register address width.
- LOAD_READY, 2: first stage index at which load data is forwardable; legal range 1..STAGES-1.
- SEL_W, $clog2(STAGES): forward-select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all tracked state.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rd  in  REG_W  destination register of the ID instruction.
- id_regwrite  in  1  the ID instruction writes id_rd.
- id_memtoreg  in  1  the ID instruction is a load.
- id_flagwrite  in  1  the ID instruction sets flags.
- id_ra, id_rb  in  REG_W  source registers (Rn, and Bin after the Reg2Loc mux).
- id_ra_used, id_rb_used  in  1  the source is actually read.
- id_flags_used  in  1  the ID instruction consumes flags (conditional branch).
- flush  in  1  kill the ID instruction (taken-branch squash).
- fwd_a, fwd_b  out  SEL_W  0 = register file, k = stage k result (1..STAGES-1).
- fwd_flag  out  1  1 = take live ALU flags from stage 1.
- stall  out  1  hold PC and IF/ID; inject a bubble into stage 1.
- stall_cnt  out  16  stall-cycle counter; present only with HAZARD_PERF_EN.

## Operation
- State: per stage k, a record of {valid, rd, regwrite, memtoreg, flagwrite}.
- Each rising edge:
  - stage k <= stage k-1 for k = 2..STAGES.
  - stage 1 <= ID record, with valid = id_valid & ~flush & ~stall.
  - Stalled and flushed cycles therefore insert a bubble into stage 1.
- Match(k, r) = valid_k & regwrite_k & (rd_k == r) & (r != 31).
  - Register 31 is XZR and is never matched.
- Operand forwarding, for each port independently (A shown; B identical):
  - fwd_a = the smallest k in 1..STAGES-1 with Match(k, id_ra) & id_ra_used; otherwise 0.
  - The youngest producer always wins.
  - Stage STAGES is never forwarded. The register file writes on the falling clock edge, so the ID stage reads the WR value directly.
- Load-use stall:
  - stall = id_valid & ~flush & ∃k < LOAD_READY such that (Match(k, id_ra) & id_ra_used | Match(k, id_rb) & id_rb_used) & memtoreg_k.
  - When stall is asserted, that port's fwd value is don't-care.
- Flag forwarding:
  - fwd_flag = valid_1 & flagwrite_1 & id_flags_used.
  - Flag consumers never stall.
- Flush has priority over stall: when flush is asserted, stall is 0 and the ID instruction is dropped.
- In-flight stages are never flushed. Older instructions always complete.

## Timing
- fwd_a, fwd_b, fwd_flag and stall are combinational from registered state and ID inputs in the same cycle. There is no output register.
- Stall duration for a load at stage k: LOAD_READY - k cycles. With the defaults, a load directly followed by a dependent instruction stalls for exactly 1 cycle; the next cycle gives fwd = 2.
- Reset (asynchronous, including mid-operation): all valid bits are 0 immediately.
  - Consequently fwd_a = fwd_b = 0, fwd_flag = 0 and stall = 0 while reset is held and in the first cycle after release.
  - stall_cnt resets to 0.
- Simultaneous events:
  - The same register matched in several stages: the lowest k wins.
  - A matches a load needing a stall while B matches a ready result: stall = 1.
  - Both ports naming the same register get the same select.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every rising edge with stall = 1.
  - It saturates at 16'hFFFF and is cleared by reset.
- HAZARD_PERF_EN undefined: the stall_cnt port and the counter logic are absent.
- All other behaviour is identical in both builds.

## Test plan
- **ALU forward:** issue ADDS X1 (rd=1, regwrite) then ID reads ra=1 -> fwd_a=1; next cycle with ra=1 -> fwd_a=2; the cycle after -> fwd_a=0.
- **Load-use:** LDUR X2 (memtoreg) then ID rb=2 used -> stall=1 for 1 cycle, stage 1 holds a bubble; next cycle fwd_b=2 and stall=0. With HAZARD_PERF_EN, stall_cnt = 1.
- **Priority and XZR:**
  - Stage 1 and stage 2 both write X5, ID ra=5 -> fwd_a=1.
  - Stage 1 writes X31, ID ra=31 -> fwd_a=0.
  - id_ra_used=0 with a matching ra -> fwd_a=0.
- **Flags:** stage 1 SUBS (flagwrite=1), ID B.LT (id_flags_used=1) -> fwd_flag=1; with stage 1 a bubble -> fwd_flag=0.
- **Flush vs stall:** load at stage 1, dependent instruction in ID with flush=1 -> stall=0; the next cycle stage 1 valid=0.
- **Reset and parameters:**
  - Assert reset asynchronously mid-stream -> all outputs 0 without waiting for a clock edge.
  - Rerun the load-use scenario with STAGES=5, LOAD_READY=3 -> stall for 2 cycles, then fwd=3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: tracks in-flight destination records after ID and
// drives operand/flag forward selects plus load-use stall. HAZARD_PERF_EN adds stall_cnt.
module hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int REG_W      = 5,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(STAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             id_flagwrite,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_ra_used,
  input  logic             id_rb_used,
  input  logic             id_flags_used,
  input  logic             flush,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic             fwd_flag,
  output logic             stall
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  // Bit/element k holds the record of the instruction k stages past ID.
  logic [STAGES:1]            vld_q, rw_q, mtr_q, fw_q;
  logic [STAGES:1][REG_W-1:0] rd_q;

  logic                vld_d;
  logic [STAGES-1:1]   match_a, match_b;
  logic                load_hit;
  logic                unused_state;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 1; k < STAGES; k++) begin
      match_a[k] = vld_q[k] & rw_q[k] & (rd_q[k] == id_ra) & (id_ra != XZR) & id_ra_used;
      match_b[k] = vld_q[k] & rw_q[k] & (rd_q[k] == id_rb) & (id_rb != XZR) & id_rb_used;
    end
  end

  // Scan oldest to youngest so the youngest producer overwrites the select.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (match_a[k]) fwd_a = SEL_W'(k);
      if (match_b[k]) fwd_b = SEL_W'(k);
    end
  end

  always_comb begin
    load_hit = 1'b0;
    for (int k = 1; k < LOAD_READY; k++) begin
      if ((match_a[k] | match_b[k]) & mtr_q[k]) load_hit = 1'b1;
    end
  end

  assign stall    = id_valid & ~flush & load_hit;
  assign fwd_flag = vld_q[1] & fw_q[1] & id_flags_used;
  assign vld_d    = id_valid & ~flush & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      rw_q  <= '0;
      mtr_q <= '0;
      fw_q  <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= {vld_q[STAGES-1:1], vld_d};
      rw_q  <= {rw_q[STAGES-1:1],  id_regwrite};
      mtr_q <= {mtr_q[STAGES-1:1], id_memtoreg};
      fw_q  <= {fw_q[STAGES-1:1],  id_flagwrite};
      rd_q  <= {rd_q[STAGES-1:1],  id_rd};
    end
  end

  // The WR-stage record and late-stage load/flag bits only exist to age out.
  assign unused_state = ^{vld_q, rw_q, mtr_q, fw_q, rd_q};

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default instance (3 stages) and a deep one (5 stages,
// loads ready at stage 3) share ID inputs; expected outputs go through a queue.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw, mtr, fw;
    logic [4:0] ra;
    logic       rau;
    logic [4:0] rb;
    logic       rbu, fu, fl;
  } id_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid, id_regwrite, id_memtoreg, id_flagwrite;
  logic id_ra_used, id_rb_used, id_flags_used, flush;
  logic [4:0] id_rd, id_ra, id_rb;

  logic [1:0] fwd_a1, fwd_b1;
  logic [2:0] fwd_a2, fwd_b2;
  logic fwd_flag1, stall1, fwd_flag2, stall2;
`ifdef HAZARD_PERF_EN
  logic [15:0] cnt1, cnt2;
`endif

  int total = 0;
  int bad = 0;
  int exp_cnt1 = 0;
  logic [7:0] exp_q[$];

  hazard_scoreboard dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_flagwrite(id_flagwrite),
    .id_ra(id_ra), .id_rb(id_rb), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
    .id_flags_used(id_flags_used), .flush(flush),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .fwd_flag(fwd_flag1), .stall(stall1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(cnt1)
`endif
  );

  hazard_scoreboard #(.STAGES(5), .LOAD_READY(3)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_flagwrite(id_flagwrite),
    .id_ra(id_ra), .id_rb(id_rb), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
    .id_flags_used(id_flags_used), .flush(flush),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .fwd_flag(fwd_flag2), .stall(stall2)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(cnt2)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  wire [7:0] obs1 = {1'b0, fwd_a1, 1'b0, fwd_b1, fwd_flag1, stall1};
  wire [7:0] obs2 = {fwd_a2, fwd_b2, fwd_flag2, stall2};

  function automatic id_t ins(input logic v, input int rd, input logic rw, mtr, fw,
                              input int ra, input logic rau, input int rb,
                              input logic rbu, fu, fl);
    id_t s;
    s.v = v; s.rd = 5'(rd); s.rw = rw; s.mtr = mtr; s.fw = fw;
    s.ra = 5'(ra); s.rau = rau; s.rb = 5'(rb); s.rbu = rbu; s.fu = fu; s.fl = fl;
    return s;
  endfunction

  function automatic logic [7:0] eo(input int a, input int b, input logic f, input logic s);
    return {3'(a), 3'(b), f, s};
  endfunction

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  // Driver tasks
  task automatic drive_id(input id_t s);
    id_valid = s.v; id_rd = s.rd; id_regwrite = s.rw; id_memtoreg = s.mtr;
    id_flagwrite = s.fw; id_ra = s.ra; id_ra_used = s.rau; id_rb = s.rb;
    id_rb_used = s.rbu; id_flags_used = s.fu; flush = s.fl;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_id(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    exp_cnt1 = 0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    drive_id(ins(1, 3, 1, 1, 1, 1, 1, 1, 1, 1, 0));
    exp_q.push_back(8'h00);
    #2;
    e = exp_q.pop_front();
    total++;
    if (obs1 !== e || obs2 !== e) begin
      bad++;
      $display("FAIL reset_held got=%h/%h exp=%h", obs1, obs2, e);
    end
`ifdef HAZARD_PERF_EN
    total++;
    if (cnt1 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt1); end
`endif
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(8'h00);
    #2;
    e = exp_q.pop_front();
    total++;
    if (obs1 !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs1, e); end
  endtask

  task automatic test_alu_forward();
    id_t st[4];
    logic [7:0] ex[4];
    logic [7:0] e;
    st[0] = ins(1, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0); ex[0] = eo(0, 0, 0, 0);
    st[1] = ins(1, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0); ex[1] = eo(1, 0, 0, 0);
    st[2] = ins(1, 0, 0, 0, 0, 1, 1, 3, 1, 0, 0); ex[2] = eo(2, 1, 0, 0);
    st[3] = ins(1, 0, 0, 0, 0, 1, 1, 3, 1, 0, 0); ex[3] = eo(0, 2, 0, 0);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_id(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if ((obs1 & (e[0] ? 8'h03 : 8'hFF)) !== (e & (e[0] ? 8'h03 : 8'hFF))) begin
        bad++;
        $display("FAIL alu_forward step=%0d got=%h exp=%h", i, obs1, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    id_t st[4];
    logic [7:0] ex[4];
    logic [7:0] e;
    st[0] = ins(1, 2, 1, 1, 0, 9, 1, 0, 0, 0, 0);  ex[0] = eo(0, 0, 0, 0);
    st[1] = ins(1, 4, 1, 0, 0, 0, 0, 2, 1, 0, 0);  ex[1] = eo(0, 0, 0, 1);
    st[2] = ins(1, 4, 1, 0, 0, 4, 1, 2, 1, 0, 0);  ex[2] = eo(0, 2, 0, 0);
    st[3] = ins(1, 10, 1, 0, 0, 4, 1, 0, 0, 0, 0); ex[3] = eo(1, 0, 0, 0);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_id(st[i]);
      exp_q.push_back(ex[i]);
      if (ex[i][0]) exp_cnt1++;
      #2;
      e = exp_q.pop_front();
      total++;
      if ((obs1 & (e[0] ? 8'h03 : 8'hFF)) !== (e & (e[0] ? 8'h03 : 8'hFF))) begin
        bad++;
        $display("FAIL load_use step=%0d got=%h exp=%h", i, obs1, e);
      end
      @(negedge clk);
    end
`ifdef HAZARD_PERF_EN
    total++;
    if (cnt1 !== 16'(exp_cnt1)) begin
      bad++;
      $display("FAIL load_use_cnt got=%0d exp=%0d", cnt1, exp_cnt1);
    end
`endif
  endtask

  task automatic test_priority_xzr();
    id_t st[4];
    logic [7:0] ex[4];
    logic [7:0] e;
    st[0] = ins(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);   ex[0] = eo(0, 0, 0, 0);
    st[1] = ins(1, 5, 1, 0, 0, 5, 1, 5, 1, 0, 0);   ex[1] = eo(1, 1, 0, 0);
    st[2] = ins(1, 31, 1, 0, 0, 5, 1, 5, 0, 0, 0);  ex[2] = eo(1, 0, 0, 0);
    st[3] = ins(1, 0, 0, 0, 0, 31, 1, 5, 1, 0, 0);  ex[3] = eo(0, 2, 0, 0);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_id(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin
        bad++;
        $display("FAIL priority_xzr step=%0d got=%h exp=%h", i, obs1, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flags();
    id_t st[5];
    logic [7:0] ex[5];
    logic [7:0] e;
    st[0] = ins(1, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0); ex[0] = eo(0, 0, 0, 0);
    st[1] = ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); ex[1] = eo(0, 0, 1, 0);
    st[2] = ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); ex[2] = eo(0, 0, 0, 0);
    st[3] = ins(0, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0); ex[3] = eo(0, 0, 0, 0);
    st[4] = ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); ex[4] = eo(0, 0, 0, 0);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_id(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin
        bad++;
        $display("FAIL flags step=%0d got=%h exp=%h", i, obs1, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush_stall();
    id_t st[3];
    logic [7:0] ex[3];
    logic [7:0] e;
    st[0] = ins(1, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0); ex[0] = eo(0, 0, 0, 0);
    st[1] = ins(1, 8, 1, 0, 0, 6, 1, 0, 0, 0, 1); ex[1] = eo(1, 0, 0, 0);
    st[2] = ins(1, 9, 1, 0, 0, 8, 1, 6, 1, 0, 0); ex[2] = eo(0, 2, 0, 0);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_id(st[i]);
      exp_q.push_back(ex[i]);
      #2;
      e = exp_q.pop_front();
      total++;
      if (obs1 !== e) begin
        bad++;
        $display("FAIL flush_stall step=%0d got=%h exp=%h", i, obs1, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    apply_reset();
    drive_id(ins(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive_id(ins(1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0));
    exp_q.push_back(eo(0, 0, 0, 1));
    #2;
    e = exp_q.pop_front();
    total++;
    if (stall1 !== e[0]) begin bad++; $display("FAIL async_pre got=%b exp=%b", stall1, e[0]); end
    #1 reset = 1'b1;
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front();
    total++;
    if (obs1 !== e || obs2 !== e) begin
      bad++;
      $display("FAIL async_reset got=%h/%h exp=%h", obs1, obs2, e);
    end
    exp_cnt1 = 0;
`ifdef HAZARD_PERF_EN
    total++;
    if (cnt1 !== 16'(exp_cnt1)) begin
      bad++;
      $display("FAIL async_cnt got=%0d exp=%0d", cnt1, exp_cnt1);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(8'h00);
    #2;
    e = exp_q.pop_front();
    total++;
    if (obs1 !== e) begin bad++; $display("FAIL async_release got=%h exp=%h", obs1, e); end
  endtask

  task automatic test_deep_params();
    id_t st[6];
    logic [7:0] ex[6];
    logic [7:0] e;
    int stalls;
    stalls = 0;
    st[0] = ins(1, 2, 1, 1, 0, 9, 1, 0, 0, 0, 0);  ex[0] = eo(0, 0, 0, 0);
    st[1] = ins(1, 4, 1, 0, 0, 0, 0, 2, 1, 0, 0);  ex[1] = eo(0, 0, 0, 1);
    st[2] = ins(1, 4, 1, 0, 0, 0, 0, 2, 1, 0, 0);  ex[2] = eo(0, 0, 0, 1);
    st[3] = ins(1, 4, 1, 0, 0, 4, 1, 2, 1, 0, 0);  ex[3] = eo(0, 3, 0, 0);
    st[4] = ins(1, 11, 1, 0, 0, 4, 1, 2, 1, 0, 0); ex[4] = eo(1, 4, 0, 0);
    st[5] = ins(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);  ex[5] = eo(0, 0, 0, 0);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_id(st[i]);
      exp_q.push_back(ex[i]);
      if (ex[i][0]) stalls++;
      #2;
      e = exp_q.pop_front();
      total++;
      if ((obs2 & (e[0] ? 8'h03 : 8'hFF)) !== (e & (e[0] ? 8'h03 : 8'hFF))) begin
        bad++;
        $display("FAIL deep_params step=%0d got=%h exp=%h", i, obs2, e);
      end
      @(negedge clk);
    end
`ifdef HAZARD_PERF_EN
    total++;
    if (cnt2 !== 16'(stalls)) begin
      bad++;
      $display("FAIL deep_cnt got=%0d exp=%0d", cnt2, stalls);
    end
`endif
  endtask

  // Random traffic against a reference model of the default configuration.
  task automatic test_random();
    logic [3:1] m_v, m_rw, m_mtr, m_fw;
    logic [4:0] m_rd [1:3];
    id_t s;
    int a, b;
    logic st, fl;
    logic [7:0] e, m;
    m_v = '0; m_rw = '0; m_mtr = '0; m_fw = '0;
    for (int k = 1; k <= 3; k++) m_rd[k] = '0;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      s.v = ($urandom_range(0, 7) != 0); s.rd = pick_reg();
      s.rw = ($urandom_range(0, 3) != 0); s.mtr = ($urandom_range(0, 2) == 0);
      s.fw = $urandom_range(0, 1) == 1; s.ra = pick_reg(); s.rau = $urandom_range(0, 3) != 0;
      s.rb = pick_reg(); s.rbu = $urandom_range(0, 3) != 0; s.fu = $urandom_range(0, 1) == 1;
      s.fl = ($urandom_range(0, 7) == 0);
      a = 0; b = 0; st = 1'b0;
      for (int k = 2; k >= 1; k--) begin
        if (m_v[k] && m_rw[k] && m_rd[k] == s.ra && s.ra != 5'd31 && s.rau) a = k;
        if (m_v[k] && m_rw[k] && m_rd[k] == s.rb && s.rb != 5'd31 && s.rbu) b = k;
      end
      if (m_mtr[1] && m_v[1] && m_rw[1] &&
          ((m_rd[1] == s.ra && s.ra != 5'd31 && s.rau) ||
           (m_rd[1] == s.rb && s.rb != 5'd31 && s.rbu))) st = 1'b1;
      st = st & s.v & ~s.fl;
      fl = m_v[1] & m_fw[1] & s.fu;
      drive_id(s);
      exp_q.push_back(eo(a, b, fl, st));
      if (st) exp_cnt1++;
      #2;
      e = exp_q.pop_front();
      m = e[0] ? 8'h03 : 8'hFF;
      total++;
      if ((obs1 & m) !== (e & m)) begin
        bad++;
        $display("FAIL random step=%0d got=%h exp=%h", i, obs1, e);
      end
      for (int k = 3; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rw[k] = m_rw[k-1]; m_mtr[k] = m_mtr[k-1];
        m_fw[k] = m_fw[k-1]; m_rd[k] = m_rd[k-1];
      end
      m_v[1] = s.v & ~s.fl & ~st; m_rw[1] = s.rw; m_mtr[1] = s.mtr;
      m_fw[1] = s.fw; m_rd[1] = s.rd;
      @(negedge clk);
    end
`ifdef HAZARD_PERF_EN
    total++;
    if (cnt1 !== 16'(exp_cnt1)) begin
      bad++;
      $display("FAIL random_cnt got=%0d exp=%0d", cnt1, exp_cnt1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_priority_xzr();
    test_flags();
    test_flush_stall();
    test_async_reset();
    test_deep_params();
    test_random();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
